// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_e;

    localparam int unsigned OS_DEF = 16;

    // Stop-bit lengths in s_tick units: 1, 1.5 and 2 stop bits at OS=16.
    localparam int unsigned SB_1  = 16;
    localparam int unsigned SB_15 = 24;
    localparam int unsigned SB_2  = 32;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop metastability synchronizer for a single asynchronous input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: deframes start, D_BIT data bits (LSB first) and stop
// using an oversampling tick, delivering each byte with a done strobe.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned D_BIT   = 8,
    parameter int unsigned OS      = OS_DEF,
    parameter int unsigned SB_TICK = SB_1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tick,
    input  logic             rx,
    output logic [D_BIT-1:0] dout,
    output logic             rx_done_tick,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned SW      = $clog2(max_u(OS, SB_TICK));
    localparam int unsigned NW      = $clog2(D_BIT);
    localparam int unsigned HALF_OS = OS / 2 - 1;
    localparam int unsigned LAST_OS = OS - 1;
    localparam int unsigned LAST_SB = SB_TICK - 1;
    localparam int unsigned LAST_N  = D_BIT - 1;

    logic             rx_s;
    rx_state_e        state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [NW-1:0]    n_q, n_d;
    logic [D_BIT-1:0] shreg_q, shreg_d;
    logic [D_BIT-1:0] dout_q, dout_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic             stop_smp_q, stop_smp_d;
    logic             stop_val;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            n_q        <= '0;
            shreg_q    <= '0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
            stop_smp_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            shreg_q    <= shreg_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
            stop_smp_q <= stop_smp_d;
        end
    end

    // Stop level seen this cycle if the sample point and frame end coincide.
    assign stop_val = (s_q == SW'(HALF_OS)) ? rx_s : stop_smp_q;

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        shreg_d    = shreg_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        ferr_d     = ferr_q;
        stop_smp_d = stop_smp_q;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == SW'(HALF_OS)) begin
                        // Line back high at start-bit centre: treat as a glitch.
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(LAST_OS)) begin
                        s_d     = '0;
                        shreg_d = {rx_s, shreg_q[D_BIT-1:1]};
                        if (n_q == NW'(LAST_N)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(HALF_OS)) begin
                        stop_smp_d = rx_s;
                    end
                    if (s_q == SW'(LAST_SB)) begin
                        dout_d  = shreg_q;
                        ferr_d  = ~stop_val;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: OS=16, SB_TICK=16, s_tick every 4 clk.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick = 1'b0;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    logic [1:0] cnt = 2'd0;
    logic       tick_en = 1'b1;
    int         cyc = 0;
    int         start_cyc = 0;
    int         strobe_cyc = 0;
    logic       prev_done = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] byte_q[$];
    logic       ferr_q[$];
    int         lat;

    uart_rx_ctrl #(.D_BIT(8), .OS(16), .SB_TICK(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Free-running tick generator: one s_tick every 4 clk, gated by tick_en.
    always @(posedge clk) begin
        cnt    <= cnt + 2'd1;
        s_tick <= tick_en && (cnt == 2'd2);
        cyc    <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every strobe; the strobe must never be high on consecutive cycles.
    always @(negedge clk) begin
        if (rst && rx_done_tick) begin
            check("no_back2back", 32'(prev_done), 32'd0);
            byte_q.push_back(dout);
            ferr_q.push_back(frame_err);
            strobe_cyc <= cyc;
        end
        prev_done <= rx_done_tick;
    end

    task automatic hold(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Put the start edge on a fixed phase of the tick grid so sample points are exact.
    task automatic align();
        for (int i = 0; i < 4 && cnt != 2'd1; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int pause_bit);
        int nq;
        align();
        start_cyc = cyc;
        hold(1'b0, 64);
        for (int i = 0; i < 8; i++) begin
            if (i == pause_bit) begin
                hold(data[i], 20);
                nq = byte_q.size();
                tick_en = 1'b0;
                hold(data[i], 50);
                check("t6_busy_frozen", 32'(busy), 32'd1);
                check("t6_no_strobe_frozen", 32'(byte_q.size()), 32'(nq));
                hold(data[i], 50);
                tick_en = 1'b1;
                hold(data[i], 44);
            end else begin
                hold(data[i], 64);
            end
        end
        hold(stop_bit, 64);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] b, input logic fe);
        check({tag, "_seen"}, 32'(byte_q.size() != 0), 32'd1);
        if (byte_q.size() != 0) begin
            check({tag, "_dout"}, 32'(byte_q.pop_front()), 32'(b));
            check({tag, "_ferr"}, 32'(ferr_q.pop_front()), 32'(fe));
        end
    endtask

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_done", 32'(rx_done_tick), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        hold(1'b1, 40);

        // 1: single frame 0x55, good stop; strobe near the stop-bit centre.
        byte_q.delete(); ferr_q.delete();
        send_frame(8'h55, 1'b1, -1);
        hold(1'b1, 64);
        check("t1_count", 32'(byte_q.size()), 32'd1);
        lat = strobe_cyc - start_cyc;
        check("t1_latency", 32'(lat >= 604 && lat <= 616), 32'd1);
        expect_frame("t1", 8'h55, 1'b0);
        check("t1_dout_port", 32'(dout), 32'h55);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2: back-to-back frames with no idle gap.
        byte_q.delete(); ferr_q.delete();
        send_frame(8'hA3, 1'b1, -1);
        send_frame(8'h0F, 1'b1, -1);
        hold(1'b1, 64);
        check("t2_count", 32'(byte_q.size()), 32'd2);
        expect_frame("t2a", 8'hA3, 1'b0);
        expect_frame("t2b", 8'h0F, 1'b0);

        // 3: short low pulse (3 ticks) is rejected at the start-bit centre.
        byte_q.delete(); ferr_q.delete();
        align();
        hold(1'b0, 12);
        hold(1'b1, 100);
        check("t3_count", 32'(byte_q.size()), 32'd0);
        check("t3_dout_held", 32'(dout), 32'h0F);
        check("t3_busy", 32'(busy), 32'd0);

        // 4: stop bit low gives a frame error.
        byte_q.delete(); ferr_q.delete();
        send_frame(8'hC4, 1'b0, -1);
        hold(1'b1, 200);
        check("t4_count", 32'(byte_q.size()), 32'd1);
        expect_frame("t4", 8'hC4, 1'b1);
        check("t4_ferr_port", 32'(frame_err), 32'd1);

        // 5: reset in the middle of data bit 4 aborts the frame.
        byte_q.delete(); ferr_q.delete();
        align();
        hold(1'b0, 64);
        hold(1'b0, 64);
        hold(1'b1, 64);
        hold(1'b0, 64);
        hold(1'b1, 64);
        hold(1'b1, 30);
        rst = 1'b0;
        #1;
        check("t5_rst_dout", 32'(dout), 32'd0);
        check("t5_rst_done", 32'(rx_done_tick), 32'd0);
        check("t5_rst_ferr", 32'(frame_err), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        hold(1'b1, 10);
        rst = 1'b1;
        hold(1'b1, 700);
        check("t5_no_strobe", 32'(byte_q.size()), 32'd0);
        send_frame(8'h3C, 1'b1, -1);
        hold(1'b1, 64);
        check("t5_count", 32'(byte_q.size()), 32'd1);
        expect_frame("t5", 8'h3C, 1'b0);

        // 6: s_tick stalled for 100 clk inside data bit 3, line bit stretched to match.
        byte_q.delete(); ferr_q.delete();
        send_frame(8'h81, 1'b1, 3);
        hold(1'b1, 64);
        check("t6_count", 32'(byte_q.size()), 32'd1);
        expect_frame("t6", 8'h81, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
